// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: per-stage enables and valids for a STAGES-deep
// elastic pipeline, with a timed flush sequence, global hold and a drop counter.
module pipe_flow_ctrl #(
    parameter int STAGES       = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16,
    localparam int OCC_W       = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush_req,
    input  logic              hold_req,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_flush,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    // Handshake: an item moves on a clock edge only when valid and ready are
    // both high in that cycle; neither side may depend on the other's edge.
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [7:0] FCNT_LOAD = 8'(FLUSH_CYCLES - 1);

    state_t             state_q, state_d;
    logic [7:0]         fcnt_q, fcnt_d;
    logic [STAGES-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               flush_eff;
    logic [STAGES-1:0]  run_en;
    logic [STAGES-1:0]  shift_in;
    logic               carry;
    logic [CNT_W:0]     drop_sum;

    assign flush_eff   = (state_q == FLUSH) || flush_req;
    assign stage_valid = valid_q;
    assign drop_cnt    = drop_cnt_q;

    // A stage may load when it is empty or its occupant moves on this cycle.
    always_comb begin
        run_en = '0;
        carry  = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            carry     = !valid_q[i] || carry;
            run_en[i] = carry;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    always_comb begin
        stage_flush = '0;
        stage_en    = run_en;
        in_ready    = run_en[0];
        out_valid   = valid_q[STAGES-1];
        if (flush_eff) begin
            stage_flush = '1;
            stage_en    = '1;
            in_ready    = 1'b0;
            out_valid   = 1'b0;
        end else if (hold_req) begin
            stage_en  = '0;
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    always_comb begin
        shift_in    = '0;
        shift_in[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            shift_in[i] = valid_q[i-1];
        end
        if (flush_eff) begin
            valid_d = '0;
        end else begin
            valid_d = (stage_en & shift_in) | (~stage_en & valid_q);
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            FLUSH: begin
                if (flush_req) begin
                    fcnt_d = FCNT_LOAD;
                end else if (fcnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 8'd1;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 8'd0;
            end
        endcase
    end

    // Only the flush that starts from RUN counts its victims; re-triggers find an empty pipe.
    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(occupancy);
        drop_cnt_d = drop_cnt_q;
        if (flush_req && (state_q == RUN)) begin
            drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= RUN;
            fcnt_q     <= 8'd0;
            valid_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            valid_q    <= valid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: directed scenario tasks plus a randomized run
// checked against an item-slot reference model.
module tb_pipe_flow_ctrl;

    localparam int S  = 3;
    localparam int FC = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          flush_req = 1'b0;
    logic          hold_req = 1'b0;
    logic [S-1:0]  stage_en;
    logic [S-1:0]  stage_flush;
    logic [S-1:0]  stage_valid;
    logic [1:0]    occupancy;
    logic [CW-1:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    pipe_flow_ctrl #(.STAGES(S), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush_req(flush_req),
        .hold_req(hold_req), .stage_en(stage_en), .stage_flush(stage_flush),
        .stage_valid(stage_valid), .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic iv, input logic orr, input logic fr, input logic hr);
        in_valid  = iv;
        out_ready = orr;
        flush_req = fr;
        hold_req  = hr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(1, 0, 1, 1);
        tick();
        tick();
        rstn = 1'b1;
        drive(0, 0, 0, 0);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (stage_en !== 3'b111) begin n_err++; $display("FAIL reset_stage_en got %b want 111", stage_en); end
        n_cmp++; if (stage_flush !== 3'b000) begin n_err++; $display("FAIL reset_stage_flush got %b want 000", stage_flush); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        n_cmp++; if (stage_valid !== 3'b000) begin n_err++; $display("FAIL reset_stage_valid got %b want 000", stage_valid); end
    endtask

    task automatic test_stream();
        int first_out = -1;
        int last_out = -1;
        int n_out = 0;
        logic [31:0] acc;
        do_reset();
        exp_q.delete();
        for (int c = 0; c < 12; c++) begin
            drive(c < 5, 1, 0, 0);
            #1;
            if (in_valid && in_ready) exp_q.push_back(32'(c));
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_spurious_out at cycle %0d got out_valid=1 want 0", c);
                end else begin
                    acc = exp_q.pop_front();
                    if (32'(c) - acc !== 32'd3) begin
                        n_err++; $display("FAIL stream_latency got %0d want 3", 32'(c) - acc);
                    end
                end
                if (first_out < 0) first_out = c;
                last_out = c;
                n_out++;
            end
            tick();
        end
        n_cmp++; if (n_out !== 5) begin n_err++; $display("FAIL stream_count got %0d want 5", n_out); end
        n_cmp++; if (last_out - first_out !== 4) begin n_err++; $display("FAIL stream_consecutive got span %0d want 4", last_out - first_out); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL stream_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1, 0, 0, 0);
            #1;
            if (!in_ready) break;
            tick();
        end
        n_cmp++; if (stage_valid !== 3'b111) begin n_err++; $display("FAIL bp_full_valid got %b want 111", stage_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_cmp++; if (occupancy !== 2'd3) begin n_err++; $display("FAIL bp_occupancy got %0d want 3", occupancy); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        tick();
        drive(0, 1, 0, 0);
        repeat (4) tick();
        n_cmp++; if (stage_valid !== 3'b000) begin n_err++; $display("FAIL bp_drain got %b want 000", stage_valid); end
    endtask

    task automatic test_bubble();
        do_reset();
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        n_cmp++; if (stage_valid !== 3'b100) begin n_err++; $display("FAIL bubble_setup got %b want 100", stage_valid); end
        drive(1, 0, 0, 0);
        #1;
        n_cmp++; if (stage_en !== 3'b011) begin n_err++; $display("FAIL bubble_stage_en got %b want 011", stage_en); end
        tick();
        n_cmp++; if (stage_valid !== 3'b101) begin n_err++; $display("FAIL bubble_next_valid got %b want 101", stage_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0);
        #1;
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_setup_occ got %0d want 2", occupancy); end
        drive(1, 1, 1, 0);
        #1;
        n_cmp++; if (stage_flush !== 3'b111) begin n_err++; $display("FAIL flush_c1_flush got %b want 111", stage_flush); end
        n_cmp++; if (stage_en !== 3'b111) begin n_err++; $display("FAIL flush_c1_en got %b want 111", stage_en); end
        n_cmp++; if ({in_ready, out_valid} !== 2'b00) begin n_err++; $display("FAIL flush_c1_handshake got %b want 00", {in_ready, out_valid}); end
        tick();
        drive(1, 1, 0, 0);
        #1;
        n_cmp++; if (stage_flush !== 3'b111) begin n_err++; $display("FAIL flush_c2_flush got %b want 111", stage_flush); end
        n_cmp++; if (stage_valid !== 3'b000) begin n_err++; $display("FAIL flush_c2_valid got %b want 000", stage_valid); end
        n_cmp++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL flush_drop_cnt got %0d want 2", drop_cnt); end
        tick();
        n_cmp++; if (stage_flush !== 3'b111) begin n_err++; $display("FAIL flush_c3_flush got %b want 111", stage_flush); end
        drive(0, 1, 0, 0);
        tick();
        n_cmp++; if (stage_flush !== 3'b000) begin n_err++; $display("FAIL flush_c4_flush got %b want 000", stage_flush); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_c4_in_ready got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_flush_extend();
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        #1;
        n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL ext_setup_occ got %0d want 1", occupancy); end
        drive(0, 0, 1, 0);
        tick();
        n_cmp++; if (drop_cnt !== 16'd3) begin n_err++; $display("FAIL ext_drop_first got %0d want 3", drop_cnt); end
        tick();
        drive(1, 0, 0, 0);
        #1;
        n_cmp++; if (stage_flush !== 3'b111) begin n_err++; $display("FAIL ext_c3_flush got %b want 111", stage_flush); end
        tick();
        n_cmp++; if (stage_flush !== 3'b111) begin n_err++; $display("FAIL ext_c4_flush got %b want 111", stage_flush); end
        tick();
        n_cmp++; if (stage_flush !== 3'b000) begin n_err++; $display("FAIL ext_c5_flush got %b want 000", stage_flush); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ext_c5_in_ready got %b want 1", in_ready); end
        n_cmp++; if (drop_cnt !== 16'd3) begin n_err++; $display("FAIL ext_drop_unchanged got %0d want 3", drop_cnt); end
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_hold_reset();
        do_reset();
        drive(1, 0, 0, 0);
        tick();
        tick();
        drive(1, 1, 0, 1);
        #1;
        n_cmp++; if (stage_en !== 3'b000) begin n_err++; $display("FAIL hold_stage_en got %b want 000", stage_en); end
        n_cmp++; if ({in_ready, out_valid} !== 2'b00) begin n_err++; $display("FAIL hold_handshake got %b want 00", {in_ready, out_valid}); end
        tick();
        n_cmp++; if (stage_valid !== 3'b011) begin n_err++; $display("FAIL hold_valid_kept got %b want 011", stage_valid); end
        drive(1, 1, 1, 1);
        #1;
        n_cmp++; if ({stage_flush, stage_en} !== 6'b111111) begin n_err++; $display("FAIL flush_beats_hold got %b want 111111", {stage_flush, stage_en}); end
        tick();
        drive(0, 0, 0, 0);
        rstn = 1'b0;
        #1;
        n_cmp++; if (stage_flush !== 3'b111) begin n_err++; $display("FAIL hold_midflush got %b want 111", stage_flush); end
        tick();
        rstn = 1'b1;
        #1;
        n_cmp++; if (stage_flush !== 3'b000) begin n_err++; $display("FAIL rst_midflush_flush got %b want 000", stage_flush); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_midflush_drop got %0d want 0", drop_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_midflush_in_ready got %b want 1", in_ready); end
    endtask

    // Reference: each slot holds an item id (-1 = empty); flush time is a countdown.
    task automatic test_random();
        int slot[S];
        int next_id = 0;
        int flush_left = 0;
        int drop = 0;
        int cnt;
        logic m_fl, any_empty;
        logic [S-1:0] e_valid, e_en, e_flush;
        logic e_ir, e_ov;
        logic iv, orr, fr, hr, rs;
        do_reset();
        for (int i = 0; i < S; i++) slot[i] = -1;
        for (int c = 0; c < 3000; c++) begin
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            fr  = ($urandom_range(0, 19) == 0);
            hr  = ($urandom_range(0, 9) == 0);
            rs  = ($urandom_range(0, 199) == 0);
            drive(iv, orr, fr, hr);
            rstn = !rs;
            #1;
            cnt = 0;
            for (int i = 0; i < S; i++) begin
                e_valid[i] = (slot[i] >= 0);
                if (slot[i] >= 0) cnt++;
            end
            m_fl = (flush_left > 0) || fr;
            if (m_fl) begin
                e_en = '1; e_flush = '1; e_ir = 0; e_ov = 0;
            end else if (hr) begin
                e_en = '0; e_flush = '0; e_ir = 0; e_ov = 0;
            end else begin
                e_flush = '0;
                for (int i = 0; i < S; i++) begin
                    any_empty = 0;
                    for (int j = i; j < S; j++) if (slot[j] < 0) any_empty = 1;
                    e_en[i] = any_empty || orr;
                end
                e_ir = e_en[0];
                e_ov = e_valid[S-1];
            end
            n_cmp++; if (stage_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, stage_valid, e_valid); end
            n_cmp++; if (stage_en !== e_en) begin n_err++; $display("FAIL rnd_en c=%0d got %b want %b", c, stage_en, e_en); end
            n_cmp++; if (stage_flush !== e_flush) begin n_err++; $display("FAIL rnd_flush c=%0d got %b want %b", c, stage_flush, e_flush); end
            n_cmp++; if ({in_ready, out_valid} !== {e_ir, e_ov}) begin n_err++; $display("FAIL rnd_handshake c=%0d got %b want %b", c, {in_ready, out_valid}, {e_ir, e_ov}); end
            n_cmp++; if (occupancy !== 2'(cnt)) begin n_err++; $display("FAIL rnd_occ c=%0d got %0d want %0d", c, occupancy, cnt); end
            n_cmp++; if (drop_cnt !== 16'(drop)) begin n_err++; $display("FAIL rnd_drop c=%0d got %0d want %0d", c, drop_cnt, drop); end
            if (rs) begin
                for (int i = 0; i < S; i++) slot[i] = -1;
                flush_left = 0;
                drop = 0;
            end else begin
                if (fr && flush_left == 0) drop = (drop + cnt > 65535) ? 65535 : drop + cnt;
                if (m_fl) begin
                    for (int i = 0; i < S; i++) slot[i] = -1;
                end else if (!hr) begin
                    for (int i = S - 1; i >= 0; i--) begin
                        if (e_en[i]) begin
                            if (i == 0) begin
                                slot[0] = iv ? next_id : -1;
                                if (iv) next_id++;
                            end else begin
                                slot[i] = slot[i-1];
                            end
                        end
                    end
                end
                if (fr) flush_left = FC;
                else if (flush_left > 0) flush_left--;
            end
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_flush_extend();
        test_hold_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 Parameter STAGES, default 3, number of en/flush registers sequenced (legal range 1..16).
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles the flush state is held (legal range 1..255).
REQ-003 Parameter CNT_W, default 16, width of the drop counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-006 in_valid  input  1  upstream item present at stage 0 input.
REQ-007 in_ready  output  1  stage 0 accepts this cycle.
REQ-008 out_valid  output  1  item present at last stage output.
REQ-009 out_ready  input  1  downstream accepts this cycle.
REQ-010 flush_req  input  1  discard all in-flight items.
REQ-011 hold_req  input  1  freeze whole pipeline.
REQ-012 stage_en  output  STAGES  enable per datapath register; bit 0 = input stage.
REQ-013 stage_flush  output  STAGES  flush per datapath register.
REQ-014 stage_valid  output  STAGES  valid bit per stage.
REQ-015 occupancy  output  $clog2(STAGES+1)  popcount of stage_valid.
REQ-016 drop_cnt  output  CNT_W  total valid items discarded by flushes, saturating.

Function
REQ-017 FSM states RUN and FLUSH; flush counter fcnt of 8 bits.
REQ-018 RUN: flush_req=1 -> FLUSH, fcnt loaded FLUSH_CYCLES-1; otherwise stay RUN.
REQ-019 FLUSH: flush_req=1 reloads fcnt to FLUSH_CYCLES-1 and stays FLUSH; else fcnt=0 -> RUN, else fcnt decrements.
REQ-020 Flush is effective combinationally: in any cycle with state==FLUSH or flush_req=1, stage_flush all ones, stage_en all ones, in_ready=0, out_valid=0, and all stage_valid bits clear at next edge.
REQ-021 Otherwise stage_flush all zeros.
REQ-022 hold_req=1 (no flush effective): stage_en all zeros, in_ready=0, out_valid=0, stage_valid unchanged.
REQ-023 Normal RUN (no flush, no hold): stage_en[STAGES-1] = !stage_valid[STAGES-1] | out_ready.
REQ-024 Normal RUN: stage_en[i] = !stage_valid[i] | stage_en[i+1] for i<STAGES-1 (bubbles collapse, zero added latency).
REQ-025 Normal RUN: in_ready = stage_en[0]; out_valid = stage_valid[STAGES-1].
REQ-026 stage_en[i]=1 loads stage_valid[i] from stage_valid[i-1] (stage 0 from in_valid); stage_en[i]=0 holds it.
REQ-027 Latency in_valid&&in_ready to out_valid: exactly STAGES cycles with out_ready=1 and no hold/flush.
REQ-028 Throughput: one item per cycle sustained with out_ready=1.
REQ-029 Items never duplicated, reordered or lost except by flush.
REQ-030 Flush with hold_req=1 simultaneously: flush wins.
REQ-031 Handshake occurring on a flush_req cycle is discarded: in_ready already 0, out_valid already 0.
REQ-032 drop_cnt increments by occupancy at each edge where flush_req=1 and state==RUN; saturates at all-ones, never wraps.
REQ-033 occupancy is combinational popcount of stage_valid.

Reset
REQ-034 rstn=0 at edge: state RUN, fcnt 0, stage_valid 0, drop_cnt 0.
REQ-035 Outputs after reset: in_ready=1, out_valid=0, stage_en all ones, stage_flush 0, occupancy 0.
REQ-036 Reset overrides flush_req, hold_req and any in-progress FLUSH state.

Verification (STAGES=3, FLUSH_CYCLES=2, CNT_W=16)
REQ-037 Stream: in_valid=1 for 5 cycles, out_ready=1 -> out_valid first high 3 cycles after first accept, high 5 consecutive cycles.
REQ-038 Backpressure: fill 3 items with out_ready=0 -> in_ready=0 once stage_valid=3'b111, occupancy=3. Raise out_ready -> in_ready=1 same cycle.
REQ-039 Bubble collapse: stage_valid=3'b100, out_ready=0, in_valid=1 -> stage_en=3'b011; next stage_valid=3'b101.
REQ-040 Flush: occupancy=2, flush_req pulse one cycle -> stage_flush=3'b111 that cycle plus 2 more cycles, stage_valid=0, drop_cnt=2, in_ready=1 in 4th cycle.
REQ-041 Flush during FLUSH: flush_req again in 2nd flush cycle -> FLUSH extended 2 cycles from that point; drop_cnt unchanged.
REQ-042 Hold+reset: hold_req=1 with stage_valid=3'b011 -> stage_en=0, stage_valid held. Assert rstn=0 mid-FLUSH -> next cycle RUN, drop_cnt=0.
